pow2_accum: RTL and testbench
=============================

// Module: pow2_accum
// PURPOSE
//   Downstream consumer of pow2 results. Accepts a stream of power-of-two values on a
//   valid/yumi input and sums each group of els_p of them. It then presents the sum on a
//   valid/yumi output, with an element count and a sticky overflow flag.
//   A flush input closes a partial group early.
// PARAMETERS
//   width_p  32  data width of input values and of the sum
//   els_p     4  number of inputs summed per output group (>=1)
//   cnt_w    derived: $clog2(els_p+1), width of the element counter and count_o
// PORTS
//   clk_i       in   1        clock; all state updates on posedge
//   reset_i     in   1        asynchronous, active-high reset
//   v_i         in   1        input value valid (from pow2 v_o)
//   data_i      in   width_p  input value (from pow2 data_o)
//   yumi_o      out  1        input consumed this cycle (drives pow2 yumi_i)
//   flush_i     in   1        close the current partial group (single-cycle pulse)
//   v_o         out  1        group result valid
//   data_o      out  width_p  group sum, modulo 2^width_p
//   count_o     out  cnt_w    number of inputs summed into data_o
//   overflow_o  out  1        a carry out of width_p occurred within this group
//   yumi_i      in   1        downstream consumed the result; legal only when v_o=1
// BEHAVIOUR
//   Reset (async assert, released synchronously by the environment)
//   - state=ACCUM, sum_r=0, cnt_r=0, ovf_r=0.
//   - v_o=0, data_o=0, count_o=0, overflow_o=0, yumi_o=0.
//   - yumi_o is forced 0 while reset_i=1.
//   FSM states: ACCUM, DONE.
//   ACCUM
//   - yumi_o = v_i & ~reset_i; combinational, no bubble.
//   - On yumi_o: sum_r <= sum_r + data_i, wrapping mod 2^width_p; cnt_r <= cnt_r + 1.
//   - On yumi_o: ovf_r |= carry-out of that addition.
//   - Go to DONE when yumi_o and cnt_r == els_p-1.
//   - Go to DONE when flush_i and (cnt_r != 0 or yumi_o).
//   - If flush_i and yumi_o fire in the same cycle, the accepted value is included
//     before closing.
//   - flush_i with cnt_r==0 and no accept: ignored, stay in ACCUM.
//   DONE
//   - v_o=1; data_o=sum_r, count_o=cnt_r, overflow_o=ovf_r.
//   - These outputs are held stable until yumi_i.
//   - yumi_o=0: the upstream stage is back-pressured. flush_i is ignored.
//   - On yumi_i: sum_r<=0, cnt_r<=0, ovf_r<=0, go to ACCUM.
//   - The next input is accepted no earlier than the cycle after yumi_i.
//   Outputs in ACCUM: v_o=0; data_o, count_o and overflow_o are don't-care (drive sum_r,
//     cnt_r, ovf_r).
//   Latency: v_o rises on the first posedge after the closing accept or flush.
//   Throughput: at most one group per els_p+1 cycles.
//   Boundary conditions
//   - els_p=1: every accepted input produces its own output group, count_o=1.
//   - Full group and flush_i in the same cycle: a single group with count_o=els_p.
//   - yumi_i while v_o=0: protocol violation; ignored by the RTL, flagged by a bench
//     assertion.
//   - reset_i mid-group or in DONE: the partial sum is discarded and the block returns to
//     the reset state immediately.
// TESTING (bench style: trace replay on negedge, ROM-driven; pow2 may be replaced by a
//   trace source)
//   1. Basic group, els_p=4: inputs 1,2,4,8 back-to-back
//      -> v_o one cycle after the 4th accept; data_o=15, count_o=4, overflow_o=0.
//   2. Back-pressure: hold yumi_i=0 for 5 cycles after v_o
//      -> data_o=15 held stable; yumi_o=0 throughout despite v_i=1; the next group starts
//      only after yumi_i.
//   3. Overflow: inputs 0x80000000 x 4
//      -> data_o=0x00000000, overflow_o=1; the next group 1,1,1,1 gives data_o=4,
//      overflow_o=0 (flag cleared).
//   4. Flush: inputs 16,32, then flush_i alone -> data_o=48, count_o=2.
//      flush_i together with the 3rd input 64 -> data_o=112, count_o=3.
//      flush_i with the group empty -> no output.
//   5. Reset mid-group: accept 1,2, assert reset_i asynchronously, release
//      -> v_o=0 and yumi_o=0 during reset; the next group 4,4,4,4 gives data_o=16,
//      count_o=4.
//   6. Throughput with pow2 upstream and yumi_i tied high: 8 exponents 0..7
//      -> two results, 15 and 240, each count_o=4, no lost or duplicated inputs.

Source files
------------

// File: rtl/pow2_accum_if.sv
// Handshake bundle between the pow2 accumulator, its upstream pow2 source and its
// downstream consumer of group sums.
interface pow2_accum_if #(
    parameter int width_p = 32,
    parameter int els_p   = 4
);
    localparam int cnt_w = $clog2(els_p + 1);

    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               yumi_o;
    logic               flush_i;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic [cnt_w-1:0]   count_o;
    logic               overflow_o;
    logic               yumi_i;

    modport slave (
        input  v_i, data_i, flush_i, yumi_i,
        output yumi_o, v_o, data_o, count_o, overflow_o
    );

    modport master (
        output v_i, data_i, flush_i, yumi_i,
        input  yumi_o, v_o, data_o, count_o, overflow_o
    );
endinterface

// File: rtl/pow2_accum.sv
// Sums groups of els_p power-of-two values from a valid/yumi stream and presents each
// group sum with its element count and a sticky carry-out flag; flush closes a group early.
module pow2_accum #(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic      clk_i,
    input  logic      reset_i,
    pow2_accum_if.slave bus
);
    localparam int cnt_w = $clog2(els_p + 1);

    typedef enum logic {ACCUM, DONE} state_e;

    state_e             state_r, state_n;
    logic [width_p-1:0] sum_r, sum_n;
    logic [cnt_w-1:0]   cnt_r, cnt_n;
    logic               ovf_r, ovf_n;
    logic               accept;
    logic [width_p:0]   add_w;

    // Input is taken combinationally whenever we are collecting, so there is no bubble.
    assign accept = (state_r == ACCUM) & bus.v_i & ~reset_i;
    assign add_w  = {1'b0, sum_r} + {1'b0, bus.data_i};

    assign bus.yumi_o     = accept;
    assign bus.v_o        = (state_r == DONE);
    assign bus.data_o     = sum_r;
    assign bus.count_o    = cnt_r;
    assign bus.overflow_o = ovf_r;

    always_comb begin
        state_n = state_r;
        sum_n   = sum_r;
        cnt_n   = cnt_r;
        ovf_n   = ovf_r;
        case (state_r)
            ACCUM: begin
                if (accept) begin
                    sum_n = add_w[width_p-1:0];
                    cnt_n = cnt_r + cnt_w'(1);
                    ovf_n = ovf_r | add_w[width_p];
                end
                // A flush in the same cycle as an accept still includes that value.
                if ((accept && (cnt_r == cnt_w'(els_p - 1))) ||
                    (bus.flush_i && ((cnt_r != '0) || accept))) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.yumi_i) begin
                    sum_n   = '0;
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                    state_n = ACCUM;
                end
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ACCUM;
            sum_r   <= '0;
            cnt_r   <= '0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            sum_r   <= sum_n;
            cnt_r   <= cnt_n;
            ovf_r   <= ovf_n;
        end
    end
endmodule

// File: tb/tb_pow2_accum.sv
// Self-checking bench for pow2_accum: directed scenarios followed by random traffic,
// compared against a queue-based model that sums each closed group with plain arithmetic.
module tb_pow2_accum;
    localparam int W = 32;
    localparam int E = 4;

    logic clk_i = 1'b0;
    logic reset_i;

    always #5 clk_i = ~clk_i;

    pow2_accum_if #(.width_p(W), .els_p(E)) bus ();

    pow2_accum #(.width_p(W), .els_p(E)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] grp[$];
    bit           done = 1'b0;
    logic [W-1:0] exp_sum = '0;
    int           exp_cnt = 0;
    bit           exp_ovf = 1'b0;

    // Downstream must never consume a result that is not being offered.
    always @(posedge clk_i) begin
        if (!reset_i && bus.yumi_i)
            assert (bus.v_o) else $error("[TB] yumi_i asserted while v_o low");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic closeGroup();
        longint unsigned total = 0;
        foreach (grp[i]) total += 64'(grp[i]);
        exp_sum = total[W-1:0];
        exp_ovf = (total >= (64'd1 << W));
        exp_cnt = grp.size();
        done    = 1'b1;
    endtask

    // Called at a negedge: checks the registered outputs, drives one cycle of inputs,
    // checks the combinational accept, then advances the model across the posedge.
    task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit fl, input bit y);
        checkOutput("v_o", 64'(bus.v_o), 64'(done));
        if (done) begin
            checkOutput("data_o", 64'(bus.data_o), 64'(exp_sum));
            checkOutput("count_o", 64'(bus.count_o), 64'(exp_cnt));
            checkOutput("overflow_o", 64'(bus.overflow_o), 64'(exp_ovf));
        end
        bus.v_i     = v;
        bus.data_i  = d;
        bus.flush_i = fl;
        bus.yumi_i  = y & done;
        #1;
        checkOutput("yumi_o", 64'(bus.yumi_o), 64'(!done && v));
        if (done) begin
            if (y) begin
                done = 1'b0;
                grp.delete();
            end
        end else begin
            if (v) grp.push_back(d);
            if ((v && grp.size() == E) || (fl && grp.size() != 0)) closeGroup();
        end
        @(negedge clk_i);
    endtask

    initial begin
        int           idx;
        logic [W-1:0] val;

        reset_i     = 1'b1;
        bus.v_i     = 1'b1;
        bus.data_i  = 32'h5;
        bus.flush_i = 1'b0;
        bus.yumi_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("rst_v_o", 64'(bus.v_o), 64'd0);
        checkOutput("rst_data_o", 64'(bus.data_o), 64'd0);
        checkOutput("rst_count_o", 64'(bus.count_o), 64'd0);
        checkOutput("rst_overflow_o", 64'(bus.overflow_o), 64'd0);
        checkOutput("rst_yumi_o", 64'(bus.yumi_o), 64'd0);
        reset_i = 1'b0;
        bus.v_i = 1'b0;
        @(negedge clk_i);

        // Basic group then back-pressure with upstream still offering data.
        applyStimulus(1, 32'd1, 0, 0);
        applyStimulus(1, 32'd2, 0, 0);
        applyStimulus(1, 32'd4, 0, 0);
        applyStimulus(1, 32'd8, 0, 0);
        repeat (5) applyStimulus(1, 32'h100, 0, 0);
        applyStimulus(1, 32'h100, 0, 1);
        applyStimulus(0, 32'h0, 0, 0);

        // Overflow, then a clean group to show the flag was cleared.
        repeat (4) applyStimulus(1, 32'h8000_0000, 0, 0);
        applyStimulus(0, 32'h0, 0, 1);
        repeat (4) applyStimulus(1, 32'd1, 0, 0);
        applyStimulus(0, 32'h0, 0, 1);

        // Flush alone, flush with an accept, flush on an empty group.
        applyStimulus(1, 32'd16, 0, 0);
        applyStimulus(1, 32'd32, 0, 0);
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1);
        applyStimulus(1, 32'd16, 0, 0);
        applyStimulus(1, 32'd32, 0, 0);
        applyStimulus(1, 32'd64, 1, 0);
        applyStimulus(0, 32'h0, 0, 1);
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 0, 0);
        // A full group coinciding with a flush is still one group of E.
        repeat (3) applyStimulus(1, 32'd2, 0, 0);
        applyStimulus(1, 32'd2, 1, 0);
        applyStimulus(0, 32'h0, 0, 1);

        // Asynchronous reset in the middle of a group.
        applyStimulus(1, 32'd1, 0, 0);
        applyStimulus(1, 32'd2, 0, 0);
        bus.v_i    = 1'b1;
        bus.data_i = 32'd7;
        #2 reset_i = 1'b1;
        #1;
        checkOutput("midrst_v_o", 64'(bus.v_o), 64'd0);
        checkOutput("midrst_yumi_o", 64'(bus.yumi_o), 64'd0);
        checkOutput("midrst_count_o", 64'(bus.count_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        bus.v_i = 1'b0;
        grp.delete();
        done = 1'b0;
        repeat (4) applyStimulus(1, 32'd4, 0, 0);
        applyStimulus(0, 32'h0, 0, 1);

        // Streaming exponents 0..7 with the consumer always ready; data held until taken.
        idx = 0;
        for (int guard = 0; guard < 40 && idx < 8; guard++) begin
            bit taken;
            taken = !done;
            applyStimulus(1, W'(1) << idx, 0, 1);
            if (taken) idx++;
        end
        checkOutput("stream_all_taken", 64'(idx), 64'd8);
        repeat (3) applyStimulus(0, 32'h0, 0, 1);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) val = 32'h8000_0000;
            else                          val = W'(1) << $urandom_range(0, W - 1);
            applyStimulus($urandom_range(0, 3) != 0, val,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
